shared_multiplier_rr: RTL and testbench
=======================================

Name: shared_multiplier_rr

Overview:
Request-driven, time-shared signed multiplier serving n_clients pipeline blocks. It replaces the fixed-rotation shared multiplier with round-robin arbitration over active requesters only, so idle clients cost no slots. The datapath is pipelined to a configurable depth, with fixed-point rescale, rounding and optional saturation. It sits beside the pipeline_block array; each block drives one request lane and watches the broadcast result bus for its own done bit.

Parameters:
n_clients, 4, number of requesting lanes (>=1)
data_width, 16, operand and scaled-result width, signed two's complement
mul_stages, 1, multiplier pipeline registers between operand capture and result stage (>=1)
frac_shift, 15, arithmetic right shift applied to full product (0..2*data_width-2)
saturate, 1, 1 = clamp scaled result to data_width signed range; 0 = truncate (keep low bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  n_clients  per-client request level; held until that client's done pulse
a_flat  in  n_clients*data_width  operand A, lane i at [i*data_width +: data_width]
b_flat  in  n_clients*data_width  operand B, same packing
result  out  data_width  scaled, rounded, optionally saturated product (broadcast)
prod_full  out  2*data_width  unscaled full signed product (broadcast)
done  out  n_clients  one-hot pulse; bit i marks result/prod_full as belonging to client i
sat  out  1  high with done when the scaled value was clamped
busy  out  1  high while any operation is in flight

Behaviour:
- Reset (async assert, sync release): result=0, prod_full=0, done=0, sat=0, busy=0, in_flight=0, all pipeline valids=0, rr pointer=n_clients-1 so client 0 wins first.
- Eligible set: req & ~in_flight. Each cycle, at most one eligible client is granted: the first eligible index searching upward from pointer+1, wrapping modulo n_clients.
- Grant at edge E: capture a_i and b_i into stage-0 registers with a valid bit and client index; set in_flight[i]; pointer<=i. Operands are sampled only at E; later changes are ignored.
- Stage 1..mul_stages: signed product of width 2*data_width, index and valid carried alongside.
- Result stage (edge E+mul_stages+1): p=full product. If frac_shift>0, s=(p + 2^(frac_shift-1)) >>> frac_shift (round half up), computed at 2*data_width+1 bits so there is no overflow. If frac_shift=0, s=p.
- saturate=1: if s>2^(data_width-1)-1, result=max and sat=1; if s<-2^(data_width-1), result=min and sat=1; else result=s[data_width-1:0] and sat=0. saturate=0: result=s[data_width-1:0] and sat=0 always.
- prod_full=p; done=one-hot(index); all registered.
- Latency: a req first sampled at edge E gives done high in the cycle after edge E+mul_stages+1. That is mul_stages+2 cycles, constant, provided the client is granted at E.
- Throughput: one grant per cycle, with fully pipelined back-to-back issue to different clients.
- done is a single-cycle pulse. It returns to 0 on the next edge unless a different operation completes.
- in_flight[i] clears on the edge ending the cycle in which done[i]=1. The client must drop req at that same edge, or a new operation is issued (intended for continuous use).
- A client is never re-granted while in flight. Simultaneous requests are served in rr order, one per cycle.
- Result and prod_full hold their last value when done=0.
- busy = |in_flight.
- n_clients=1: the pointer is a constant and index logic degenerates. There is no special behaviour.
- Reset mid-operation: all in-flight work is discarded and no done is emitted for it. Clients must re-request after release.

Test Plan:
- data_width=16, frac_shift=15, mul_stages=1: client 0 req, a=0x4000, b=0x4000 -> 3 cycles later done=0001, result=0x2000, prod_full=0x10000000, sat=0.
- a=0x8000, b=0x8000 -> result=0x7FFF, sat=1, prod_full=0x40000000. Repeat with saturate=0 -> result=0x8000, sat=0.
- Rounding: a=0x0001, b=0x4000 -> result=0x0001. a=0xFFFF, b=0x4000 -> result=0x0000.
- All 4 clients request in the same cycle with distinct operands -> done pulses on consecutive cycles in order 0,1,2,3, each with the correct product. Client 0 re-requests immediately -> served after 3, not before.
- Clients 1 and 3 request continuously -> grants alternate 1,3,1,3 and are never granted while in flight. Idle clients 0 and 2 take no slots. busy stays high.
- Assert reset while 2 operations are in flight -> done, busy, result and prod_full are 0 immediately with no done pulse. After release, client 0 is granted first.

Source files
------------

// File: rtl/shared_multiplier_rr.sv
// ---------------------------------------------------------------------------
// shared_multiplier_rr
//
// Time-shared signed multiplier for an array of pipeline blocks. Active
// requesters are arbitrated round-robin, and at most one is granted per
// cycle. The granted operands pass through a product pipeline mul_stages
// deep. A result stage then rescales the product by frac_shift with
// round-half-up rounding and, optionally, saturates it. The registered
// result is broadcast to every client, and a one-hot done pulse names the
// client that owns it.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   req        per-client request level, held until that client's done
//   a_flat     operand A, lane i at [i*data_width +: data_width]
//   b_flat     operand B, same packing
//   result     scaled, rounded, optionally saturated product (broadcast)
//   prod_full  unscaled full signed product (broadcast)
//   done       one-hot completion pulse, bit i = client i owns the result
//   sat        high with done when the scaled value was clamped
//   busy       high while any client has an operation in flight
// ---------------------------------------------------------------------------
module shared_multiplier_rr #(
  parameter int n_clients  = 4,
  parameter int data_width = 16,
  parameter int mul_stages = 1,
  parameter int frac_shift = 15,
  parameter int saturate   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [n_clients-1:0]            req,
  input  logic [n_clients*data_width-1:0] a_flat,
  input  logic [n_clients*data_width-1:0] b_flat,
  output logic [data_width-1:0]           result,
  output logic [2*data_width-1:0]         prod_full,
  output logic [n_clients-1:0]            done,
  output logic                            sat,
  output logic                            busy
);

  localparam int IW  = (n_clients > 1) ? $clog2(n_clients) : 1;
  localparam int PW  = 2 * data_width;
  localparam int SW  = PW + 1;
  localparam int RSH = (frac_shift > 0) ? frac_shift - 1 : 0;
  localparam logic [IW-1:0] LAST_IDX = IW'(n_clients - 1);

  // Clamp limits, widened to the rounding width so the compare cannot overflow.
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-data_width+1){1'b1}}, {(data_width-1){1'b0}}};
  localparam logic [data_width-1:0] RES_MAX = {1'b0, {(data_width-1){1'b1}}};
  localparam logic [data_width-1:0] RES_MIN = {1'b1, {(data_width-1){1'b0}}};

  // Arbitration state
  logic [IW-1:0]          ptr;
  logic [n_clients-1:0]   in_flight;
  logic [n_clients-1:0]   eligible;
  logic [n_clients-1:0]   grant_onehot;
  logic [n_clients-1:0]   in_flight_next;
  logic                   grant_valid;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          cand_idx;
  logic                   hit;
  logic [data_width-1:0]  sel_a;
  logic [data_width-1:0]  sel_b;

  // Operand capture stage
  logic                   s0_valid;
  logic [IW-1:0]          s0_idx;
  logic [data_width-1:0]  s0_a;
  logic [data_width-1:0]  s0_b;

  // Product pipeline
  logic [PW-1:0]          mul_a;
  logic [PW-1:0]          mul_b;
  logic [PW-1:0]          product;
  logic [PW-1:0]          prod_pipe [1:mul_stages];
  logic                   vld_pipe  [1:mul_stages];
  logic [IW-1:0]          idx_pipe  [1:mul_stages];

  // Rescale / saturate
  logic [PW-1:0]          p_last;
  logic signed [SW-1:0]   ext_p;
  logic signed [SW-1:0]   rnd_add;
  logic signed [SW-1:0]   rnd_sum;
  logic signed [SW-1:0]   scaled;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [data_width-1:0]  scaled_res;
  logic [n_clients-1:0]   done_next;

  // Round-robin search: first eligible client above the pointer, wrapping.
  always_comb begin
    eligible    = req & ~in_flight;
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand_idx    = '0;
    hit         = 1'b0;
    for (int k = 1; k <= n_clients; k++) begin
      cand_idx    = IW'((int'(ptr) + k) % n_clients);
      hit         = eligible[cand_idx] & ~grant_valid;
      grant_idx   = hit ? cand_idx : grant_idx;
      grant_valid = grant_valid | hit;
    end
  end

  // One-hot grant and AND-OR operand selection for the granted lane.
  always_comb begin
    grant_onehot = '0;
    sel_a        = '0;
    sel_b        = '0;
    for (int i = 0; i < n_clients; i++) begin
      grant_onehot[i] = grant_valid & (grant_idx == IW'(i));
      sel_a = sel_a | (a_flat[i*data_width +: data_width] & {data_width{grant_onehot[i]}});
      sel_b = sel_b | (b_flat[i*data_width +: data_width] & {data_width{grant_onehot[i]}});
    end
  end

  // A completing client releases its slot on the edge that ends its done cycle.
  always_comb begin
    in_flight_next = (in_flight | grant_onehot) & ~done;
  end

  // Arbitration state and operand capture; operands are sampled only at grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= LAST_IDX;
      in_flight <= '0;
      busy      <= 1'b0;
      s0_valid  <= 1'b0;
      s0_idx    <= '0;
      s0_a      <= '0;
      s0_b      <= '0;
    end else begin
      in_flight <= in_flight_next;
      busy      <= |in_flight_next;
      s0_valid  <= grant_valid;
      if (grant_valid) begin
        ptr    <= grant_idx;
        s0_idx <= grant_idx;
        s0_a   <= sel_a;
        s0_b   <= sel_b;
      end else begin
        ptr    <= ptr;
        s0_idx <= s0_idx;
        s0_a   <= s0_a;
        s0_b   <= s0_b;
      end
    end
  end

  // Sign-extend to full width; the low PW bits of the product are the signed result.
  always_comb begin
    mul_a   = {{data_width{s0_a[data_width-1]}}, s0_a};
    mul_b   = {{data_width{s0_b[data_width-1]}}, s0_b};
    product = mul_a * mul_b;
  end

  // Product pipeline: stage 1 holds the product, later stages delay it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 1; s <= mul_stages; s++) begin
        prod_pipe[s] <= '0;
        vld_pipe[s]  <= 1'b0;
        idx_pipe[s]  <= '0;
      end
    end else begin
      prod_pipe[1] <= product;
      vld_pipe[1]  <= s0_valid;
      idx_pipe[1]  <= s0_idx;
      for (int s = 2; s <= mul_stages; s++) begin
        prod_pipe[s] <= prod_pipe[s-1];
        vld_pipe[s]  <= vld_pipe[s-1];
        idx_pipe[s]  <= idx_pipe[s-1];
      end
    end
  end

  // Round half up and shift one bit wider than the product so the sum cannot overflow.
  always_comb begin
    p_last       = prod_pipe[mul_stages];
    ext_p        = {p_last[PW-1], p_last};
    rnd_add      = '0;
    rnd_add[RSH] = (frac_shift > 0);
    rnd_sum      = ext_p + rnd_add;
    if (frac_shift > 0) begin
      scaled = rnd_sum >>> frac_shift;
    end else begin
      scaled = ext_p;
    end
  end

  // Optional clamp to the signed data_width range; otherwise keep the low bits.
  always_comb begin
    sat_hi = (saturate != 0) && (scaled > SAT_MAX);
    sat_lo = (saturate != 0) && (scaled < SAT_MIN);
    if (sat_hi) begin
      scaled_res = RES_MAX;
    end else if (sat_lo) begin
      scaled_res = RES_MIN;
    end else begin
      scaled_res = scaled[data_width-1:0];
    end
  end

  // One-hot owner of the completing operation.
  always_comb begin
    done_next = '0;
    for (int i = 0; i < n_clients; i++) begin
      done_next[i] = vld_pipe[mul_stages] & (idx_pipe[mul_stages] == IW'(i));
    end
  end

  // Result stage: done and sat pulse for one cycle; result and prod_full hold between operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      prod_full <= '0;
      done      <= '0;
      sat       <= 1'b0;
    end else begin
      done <= done_next;
      if (vld_pipe[mul_stages]) begin
        result    <= scaled_res;
        prod_full <= p_last;
        sat       <= sat_hi | sat_lo;
      end else begin
        result    <= result;
        prod_full <= prod_full;
        sat       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shared_multiplier_rr.sv
// ---------------------------------------------------------------------------
// tb_shared_multiplier_rr
//
// Directed bench for shared_multiplier_rr with n_clients=4, data_width=16,
// mul_stages=1 and frac_shift=15. A saturating instance and a truncating
// instance share the same stimulus. Single-client vectors come from a
// table. Hand-written sequences cover simultaneous requests, continuous
// alternating requesters, and reset in the middle of operations.
// ---------------------------------------------------------------------------
module tb_shared_multiplier_rr;

  localparam int N = 4;
  localparam int W = 16;
  localparam int M = 1;
  localparam int F = 15;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_flat;
  logic [N*W-1:0]   b_flat;
  logic [W-1:0]     result;
  logic [2*W-1:0]   prod_full;
  logic [N-1:0]     done;
  logic             sat;
  logic             busy;
  logic [W-1:0]     result_ns;
  logic [2*W-1:0]   prod_full_ns;
  logic [N-1:0]     done_ns;
  logic             sat_ns;
  logic             busy_ns;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [31:0] prod;
    logic        sat;
    logic [15:0] res_ns;
  } vec_t;

  vec_t vecs [8];

  shared_multiplier_rr #(
    .n_clients(N), .data_width(W), .mul_stages(M), .frac_shift(F), .saturate(1)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .result(result), .prod_full(prod_full), .done(done), .sat(sat), .busy(busy)
  );

  shared_multiplier_rr #(
    .n_clients(N), .data_width(W), .mul_stages(M), .frac_shift(F), .saturate(0)
  ) u_dut_ns (
    .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .result(result_ns), .prod_full(prod_full_ns), .done(done_ns), .sat(sat_ns),
    .busy(busy_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One operation on a single client: latency, outputs, then the done pulse ending.
  task automatic run_vec(input int c, input vec_t v);
    int  lat;
    bit  found;
    lat   = 0;
    found = 1'b0;
    a_flat[c*W +: W] = v.a;
    b_flat[c*W +: W] = v.b;
    req[c] = 1'b1;
    for (int k = 1; k <= 8 && !found; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("busy_issue", 64'(busy), 64'(1));
      if (done != '0) begin
        found = 1'b1;
        lat   = k;
      end
    end
    check("latency", 64'(lat), 64'(M + 2));
    check("done_onehot", 64'(done), 64'(4'b0001 << c));
    check("result", 64'(result), 64'(v.res));
    check("prod_full", 64'(prod_full), 64'(v.prod));
    check("sat", 64'(sat), 64'(v.sat));
    check("done_ns", 64'(done_ns), 64'(4'b0001 << c));
    check("result_ns", 64'(result_ns), 64'(v.res_ns));
    check("sat_ns", 64'(sat_ns), 64'(1'b0));
    req[c] = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("result_hold", 64'(result), 64'(v.res));
  endtask

  initial begin
    logic [N-1:0] exp_done [1:8];
    int           lane;

    vecs[0] = '{16'h4000, 16'h4000, 16'h2000, 32'h1000_0000, 1'b0, 16'h2000};
    vecs[1] = '{16'h8000, 16'h8000, 16'h7FFF, 32'h4000_0000, 1'b1, 16'h8000};
    vecs[2] = '{16'h0001, 16'h4000, 16'h0001, 32'h0000_4000, 1'b0, 16'h0001};
    vecs[3] = '{16'hFFFF, 16'h4000, 16'h0000, 32'hFFFF_C000, 1'b0, 16'h0000};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFE, 32'h3FFF_0001, 1'b0, 16'h7FFE};
    vecs[5] = '{16'h0003, 16'h4000, 16'h0002, 32'h0000_C000, 1'b0, 16'h0002};
    vecs[6] = '{16'hFFFD, 16'h4000, 16'hFFFF, 32'hFFFF_4000, 1'b0, 16'hFFFF};
    vecs[7] = '{16'hC000, 16'h4000, 16'hE000, 32'hF000_0000, 1'b0, 16'hE000};

    reset  = 1'b1;
    req    = '0;
    a_flat = '0;
    b_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_prod", 64'(prod_full), 64'(0));
    check("rst_sat", 64'(sat), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors, rotating through clients.
    for (int i = 0; i < 8; i++) begin
      run_vec(i % N, vecs[i]);
    end

    // All four request together; client 0 keeps requesting and must wait for 3.
    for (int i = 0; i < N; i++) begin
      a_flat[i*W +: W] = 16'(16'h1000 * (i + 1));
      b_flat[i*W +: W] = 16'h2000;
    end
    exp_done = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    req = 4'b1111;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      check("all4_done", 64'(done), 64'(exp_done[n]));
      if (exp_done[n] != '0) begin
        lane = 0;
        for (int b = 0; b < N; b++) if (exp_done[n][b]) lane = b;
        check("all4_result", 64'(result), 64'(16'(16'h0400 * (lane + 1))));
        check("all4_prod", 64'(prod_full), 64'(32'(32'h0200_0000 * (lane + 1))));
        if (!(lane == 0 && n == 3)) req[lane] = 1'b0;
      end
    end

    // Clients 1 and 3 request continuously; they alternate and idle lanes take no slot.
    a_flat[1*W +: W] = 16'h2000; b_flat[1*W +: W] = 16'h2000;
    a_flat[3*W +: W] = 16'hE000; b_flat[3*W +: W] = 16'h2000;
    exp_done = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
    req = 4'b1010;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      check("alt_done", 64'(done), 64'(exp_done[n]));
      check("alt_busy", 64'(busy), 64'(1));
      if (exp_done[n] == 4'b0010) begin
        check("alt_res1", 64'(result), 64'(16'h0800));
        check("alt_prod1", 64'(prod_full), 64'(32'h0400_0000));
      end
      if (exp_done[n] == 4'b1000) begin
        check("alt_res3", 64'(result), 64'(16'hF800));
        check("alt_prod3", 64'(prod_full), 64'(32'hFC00_0000));
      end
    end
    req = '0;
    @(posedge clk); #1;
    check("alt_drain_busy", 64'(busy), 64'(0));
    check("alt_drain_done", 64'(done), 64'(0));

    // Reset with two operations in flight: no done, everything cleared at once.
    a_flat[0*W +: W] = 16'h4000; b_flat[0*W +: W] = 16'h4000;
    req = 4'b0011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    req   = '0;
    #1;
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_result", 64'(result), 64'(0));
    check("mid_rst_prod", 64'(prod_full), 64'(0));
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      check("rst_hold_done", 64'(done), 64'(0));
    end
    @(negedge clk);
    reset = 1'b0;

    // After release the pointer restarts, so client 0 beats client 2.
    a_flat[2*W +: W] = 16'h0003; b_flat[2*W +: W] = 16'h4000;
    exp_done = '{4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    req = 4'b0101;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      check("post_rst_done", 64'(done), 64'(exp_done[n]));
      if (exp_done[n] == 4'b0001) begin
        check("post_rst_res0", 64'(result), 64'(16'h2000));
        req[0] = 1'b0;
      end
      if (exp_done[n] == 4'b0100) begin
        check("post_rst_res2", 64'(result), 64'(16'h0002));
        req[2] = 1'b0;
      end
    end
    check("post_rst_busy", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
